// File: rtl/lcd_msg_sequencer.sv
// Streams a CHARS x LINES text message to a handshaking LCD driver: clear, then address + char words per line.
// Build option LCD_SEQ_REFRESH_EN: re-capture msg and rewrite it continuously after each pass.
module lcd_msg_sequencer #(
    parameter int unsigned CHARS  = 16,
    parameter int unsigned LINES  = 2,
    parameter int unsigned ACK_TO = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [8*CHARS*LINES-1:0] msg,
    input  logic                     lcd_available,
    output logic [31:0]              data,
    output logic                     select_cd,
    output logic                     enable_writing,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);
    localparam int unsigned MSGW      = 8*CHARS*LINES;
    localparam int unsigned CNTW      = $clog2(ACK_TO + 1);
    localparam logic [2:0]  POS_LAST  = 3'(CHARS/4);
    localparam logic        LINE_LAST = 1'(LINES - 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(ACK_TO - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_RDY, FINISH} state_t;

    state_t            state_q, state_d;
    logic [MSGW-1:0]   msg_q;
    logic              clr_q;
    logic              line_q;
    logic [2:0]        pos_q;
    logic [CNTW-1:0]   cnt_q;
    logic              err_q;
    logic              last_word;
    logic              timeout;

    assign err = err_q;

    always_comb begin
        state_d        = state_q;
        enable_writing = 1'b0;
        busy           = (state_q != IDLE);
        done           = (state_q == FINISH);
        timeout        = 1'b0;
        last_word      = !clr_q && (line_q == LINE_LAST) && (pos_q == POS_LAST);
        case (state_q)
            IDLE:     if (start) state_d = ISSUE;
            ISSUE:    if (lcd_available) begin
                          enable_writing = 1'b1;
                          state_d        = WAIT_ACK;
                      end
            WAIT_ACK: if (!lcd_available) begin
                          state_d = WAIT_RDY;
                      end else if (cnt_q == CNT_LAST) begin
                          timeout = 1'b1;
                          state_d = IDLE;
                      end
            WAIT_RDY: if (lcd_available) state_d = last_word ? FINISH : ISSUE;
`ifdef LCD_SEQ_REFRESH_EN
            FINISH:   state_d = ISSUE;
`else
            FINISH:   state_d = IDLE;
`endif
            default:  state_d = IDLE;
        endcase
    end

    // Head of msg_q is always the next character word; it is shifted out as words are consumed.
    always_comb begin
        data      = '0;
        select_cd = 1'b1;
        if (state_q != IDLE) begin
            if (clr_q) begin
                data      = 32'h0000_0001;
                select_cd = 1'b0;
            end else if (pos_q == '0) begin
                data      = {24'h0, (line_q ? 8'hC0 : 8'h80)};
                select_cd = 1'b0;
            end else begin
                data      = msg_q[MSGW-1 -: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            msg_q   <= '0;
            clr_q   <= 1'b1;
            line_q  <= 1'b0;
            pos_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (start) begin
                    msg_q  <= msg;
                    clr_q  <= 1'b1;
                    line_q <= 1'b0;
                    pos_q  <= '0;
                    err_q  <= 1'b0;
                end
                ISSUE:    cnt_q <= '0;
                WAIT_ACK: begin
                    cnt_q <= cnt_q + CNTW'(1);
                    if (timeout) err_q <= 1'b1;
                end
                WAIT_RDY: if (lcd_available && !last_word) begin
                    if (clr_q) begin
                        clr_q <= 1'b0;
                    end else begin
                        if (pos_q != '0) msg_q <= msg_q << 32;
                        if (pos_q == POS_LAST) begin
                            pos_q  <= '0;
                            line_q <= ~line_q;
                        end else begin
                            pos_q  <= pos_q + 3'd1;
                        end
                    end
                end
                FINISH: begin
`ifdef LCD_SEQ_REFRESH_EN
                    msg_q  <= msg;
                    clr_q  <= 1'b0;
                    line_q <= 1'b0;
                    pos_q  <= '0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// Directed self-checking bench for lcd_msg_sequencer: a 16x2 instance and a 4x1 instance with ACK_TO=8.
module tb_lcd_msg_sequencer;
    logic clk = 1'b0;
    logic rst_n;

    logic         start1, av1, sc1, ew1, bz1, dn1, er1;
    logic [255:0] msg1;
    logic [31:0]  d1;
    logic         start2, av2, sc2, ew2, bz2, dn2, er2;
    logic [31:0]  msg2;
    logic [31:0]  d2;

    logic drv1_auto, drv1_force, drv2_auto, drv2_force;
    int ack1 = 0, ack2 = 0;
    int done1 = 0, done2 = 0;
    logic [32:0] q1[$];
    logic [32:0] q2[$];
    int n_checks = 0, n_fail = 0;
    int base, dbase, n;

    localparam logic [255:0] MSG_A = {"HELLO WORLD     ", "DE2 CYCLONE II  "};
    localparam logic [255:0] MSG_B = {32{"Z"}};
    localparam logic [32:0] EXP_MAIN [11] = '{
        {1'b0, 32'h0000_0001}, {1'b0, 32'h0000_0080},
        {1'b1, "HELL"}, {1'b1, "O WO"}, {1'b1, "RLD "}, {1'b1, "    "},
        {1'b0, 32'h0000_00C0},
        {1'b1, "DE2 "}, {1'b1, "CYCL"}, {1'b1, "ONE "}, {1'b1, "II  "}};
    localparam logic [32:0] EXP_SMALL [5] = '{
        {1'b0, 32'h0000_0001}, {1'b0, 32'h0000_0080}, {1'b1, "ABCD"},
        {1'b0, 32'h0000_0080}, {1'b1, "WXYZ"}};

    always #5 clk = ~clk;

    lcd_msg_sequencer u_main (
        .clk(clk), .rst_n(rst_n), .start(start1), .msg(msg1), .lcd_available(av1),
        .data(d1), .select_cd(sc1), .enable_writing(ew1), .busy(bz1), .done(dn1), .err(er1)
    );

    lcd_msg_sequencer #(.CHARS(4), .LINES(1), .ACK_TO(8)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start2), .msg(msg2), .lcd_available(av2),
        .data(d2), .select_cd(sc2), .enable_writing(ew2), .busy(bz2), .done(dn2), .err(er2)
    );

    // Driver model: lcd_available drops 2 cycles after a strobe and stays low for 5 cycles.
    always @(posedge clk) begin
        if (ack1 != 0) ack1 <= (ack1 == 7) ? 0 : ack1 + 1;
        else if (ew1) ack1 <= 1;
        if (ack2 != 0) ack2 <= (ack2 == 7) ? 0 : ack2 + 1;
        else if (ew2) ack2 <= 1;
    end
    assign av1 = drv1_auto ? !(ack1 >= 2 && ack1 <= 6) : drv1_force;
    assign av2 = drv2_auto ? !(ack2 >= 2 && ack2 <= 6) : drv2_force;

    always @(negedge clk) begin
        if (ew1) q1.push_back({sc1, d1});
        if (dn1) done1 <= done1 + 1;
        if (ew2) q2.push_back({sc2, d2});
        if (dn2) done2 <= done2 + 1;
    end

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start1();
        start1 = 1'b1;
        tick(1);
        start1 = 1'b0;
    endtask

    task automatic pulse_start2();
        start2 = 1'b1;
        tick(1);
        start2 = 1'b0;
    endtask

    task automatic wait_dn1(input string tag);
        int k = 0;
        while (dn1 !== 1'b1 && k < 400) begin
            tick(1);
            k++;
        end
        check({tag, "_done_seen"}, 64'(dn1), 64'd1);
    endtask

    task automatic check_main(input string tag, input int b);
        check({tag, "_count"}, 64'(q1.size() - b), 64'd11);
        for (int i = 0; i < 11; i++)
            if (b + i < q1.size())
                check($sformatf("%s_w%0d", tag, i), 64'(q1[b + i]), 64'(EXP_MAIN[i]));
    endtask

    initial begin
        rst_n = 1'b1; start1 = 1'b0; start2 = 1'b0;
        msg1 = MSG_A; msg2 = "ABCD";
        drv1_auto = 1'b1; drv1_force = 1'b1; drv2_auto = 1'b1; drv2_force = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_data", 64'(d1), 64'd0);
        check("rst_sel", 64'(sc1), 64'd1);
        check("rst_ew", 64'(ew1), 64'd0);
        check("rst_busy", 64'(bz1), 64'd0);
        check("rst_done", 64'(dn1), 64'd0);
        check("rst_err", 64'(er1), 64'd0);
        check("rst_small_err", 64'(er2), 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

`ifndef LCD_SEQ_REFRESH_EN
        // Full 16x2 sequence; a start landing in the FINISH cycle must be ignored.
        base = q1.size(); dbase = done1;
        pulse_start1();
        check("start_busy", 64'(bz1), 64'd1);
        wait_dn1("main");
        start1 = 1'b1;
        tick(1);
        start1 = 1'b0;
        check("finish_start_busy", 64'(bz1), 64'd0);
        tick(20);
        check_main("main", base);
        check("main_done_cnt", 64'(done1 - dbase), 64'd1);

        // Second start and msg change mid-sequence are ignored.
        base = q1.size(); dbase = done1;
        pulse_start1();
        n = 0;
        while (q1.size() - base < 3 && n < 200) begin tick(1); n++; end
        start1 = 1'b1; msg1 = MSG_B;
        tick(1);
        start1 = 1'b0;
        wait_dn1("dist");
        tick(20);
        check_main("dist", base);
        check("dist_done_cnt", 64'(done1 - dbase), 64'd1);
        check("dist_err", 64'(er1), 64'd0);
        msg1 = MSG_A;

        // Driver not ready at start: first strobe in the first cycle it becomes ready.
        drv1_auto = 1'b0; drv1_force = 1'b0;
        base = q1.size();
        pulse_start1();
        tick(10);
        check("hold_no_strobe", 64'(q1.size() - base), 64'd0);
        check("hold_ew", 64'(ew1), 64'd0);
        check("hold_busy", 64'(bz1), 64'd1);
        drv1_force = 1'b1; drv1_auto = 1'b1;
        #1;
        check("rise_ew", 64'(ew1), 64'd1);
        check("rise_word", 64'({sc1, d1}), 64'({1'b0, 32'h0000_0001}));
        wait_dn1("hold");
        tick(20);
        check_main("hold", base);

        // Reset asserted during the 5th strobe.
        base = q1.size();
        pulse_start1();
        n = 0;
        while (!(ew1 === 1'b1 && q1.size() - base == 4) && n < 200) begin tick(1); n++; end
        check("rst_point", 64'(q1.size() - base), 64'd4);
        rst_n = 1'b0;
        #1;
        check("mrst_ew", 64'(ew1), 64'd0);
        check("mrst_busy", 64'(bz1), 64'd0);
        check("mrst_done", 64'(dn1), 64'd0);
        check("mrst_err", 64'(er1), 64'd0);
        check("mrst_data", 64'(d1), 64'd0);
        check("mrst_sel", 64'(sc1), 64'd1);
        tick(3);
        check("mrst_no_write", 64'(q1.size() - base), 64'd4);
        rst_n = 1'b1;
        tick(5);
        check("mrst_idle", 64'(q1.size() - base), 64'd4);
        base = q1.size();
        pulse_start1();
        wait_dn1("restart");
        tick(20);
        check_main("restart", base);

        // 4x1 instance: single pass per start.
        base = q2.size(); dbase = done2;
        pulse_start2();
        n = 0;
        while (dn2 !== 1'b1 && n < 200) begin tick(1); n++; end
        tick(30);
        check("small_count", 64'(q2.size() - base), 64'd3);
        for (int i = 0; i < 3; i++)
            if (base + i < q2.size())
                check($sformatf("small_w%0d", i), 64'(q2[base + i]), 64'(EXP_SMALL[i]));
        check("small_done_cnt", 64'(done2 - dbase), 64'd1);
        check("small_busy", 64'(bz2), 64'd0);

        // Ack timeout with ACK_TO=8: driver never drops lcd_available.
        drv2_auto = 1'b0; drv2_force = 1'b1;
        base = q2.size(); dbase = done2;
        pulse_start2();
        check("to_strobe", 64'(ew2), 64'd1);
        tick(8);
        check("to_err_before", 64'(er2), 64'd0);
        check("to_busy_before", 64'(bz2), 64'd1);
        tick(1);
        check("to_err", 64'(er2), 64'd1);
        check("to_busy", 64'(bz2), 64'd0);
        tick(5);
        check("to_err_sticky", 64'(er2), 64'd1);
        check("to_no_done", 64'(done2 - dbase), 64'd0);
        check("to_one_write", 64'(q2.size() - base), 64'd1);
        pulse_start2();
        check("to_err_clear", 64'(er2), 64'd0);
        check("to_busy_again", 64'(bz2), 64'd1);
        tick(12);
`else
        // Auto-refresh on the 4x1 instance; msg changed during pass 1 shows up in pass 2.
        base = q2.size(); dbase = done2;
        pulse_start2();
        n = 0;
        while (q2.size() - base < 3 && n < 200) begin tick(1); n++; end
        check("rf_pass1_done", 64'(done2 - dbase), 64'd0);
        msg2 = "WXYZ";
        n = 0;
        while (done2 - dbase < 2 && n < 300) begin tick(1); n++; end
        check("rf_done_cnt", 64'(done2 - dbase), 64'd2);
        check("rf_busy", 64'(bz2), 64'd1);
        for (int i = 0; i < 5; i++)
            if (base + i < q2.size())
                check($sformatf("rf_w%0d", i), 64'(q2[base + i]), 64'(EXP_SMALL[i]));
        check("rf_main_idle", 64'(bz1), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_msg_sequencer.md
LCD_MSG_SEQUENCER -- requirements
Module: lcd_msg_sequencer

Interface
REQ-001 The module SHALL have parameter CHARS, default 16, meaning characters per LCD line; legal values are 4, 8, 12 or 16.
REQ-002 The module SHALL have parameter LINES, default 2, meaning LCD lines written; legal values are 1 or 2.
REQ-003 The module SHALL have parameter ACK_TO, default 1024, meaning the clock-cycle limit for the downstream driver to drop lcd_available after a write strobe.
REQ-004 The module SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port start, input, 1 bit: single-cycle request to write the full message.
REQ-007 The module SHALL have port msg, input, 8*CHARS*LINES bits: ASCII text; char 0 of line 0 is in the top byte, packed MSB-first as in a Verilog string literal.
REQ-008 The module SHALL have port lcd_available, input, 1 bit: downstream LCD driver idle/ready.
REQ-009 The module SHALL have port data, output, 32 bits: word to the driver.
REQ-010 The module SHALL have port select_cd, output, 1 bit: 1 = character data, 0 = command.
REQ-011 The module SHALL have port enable_writing, output, 1 bit: one-cycle write strobe to the driver.
REQ-012 The module SHALL have port busy, output, 1 bit: sequence in progress.
REQ-013 The module SHALL have port done, output, 1 bit: one-cycle pulse when the sequence completes.
REQ-014 The module SHALL have port err, output, 1 bit: sticky ack-timeout flag.

Function
REQ-015 The module SHALL capture msg into an internal register on an accepted start; later changes to msg SHALL NOT affect the sequence in flight.
REQ-016 The module SHALL ignore start while busy=1.
REQ-017 The module SHALL emit this write order: clear command (data=32'h0000_0001, select_cd=0); then, for each line L, a DDRAM address command (data[7:0]=8'h80 | L*8'h40, upper bits 0, select_cd=0) followed by CHARS/4 character words (select_cd=1).
REQ-018 Each character word SHALL carry 4 chars, the earliest char in data[31:24].
REQ-019 The total writes per sequence SHALL be 1 + LINES*(1+CHARS/4), which is 11 for the defaults.
REQ-020 The module SHALL implement FSM states IDLE, ISSUE, WAIT_ACK, WAIT_RDY and FINISH.
REQ-021 IDLE -> ISSUE SHALL occur on start.
REQ-022 ISSUE SHALL hold data/select_cd stable and pulse enable_writing for exactly one cycle, but only in a cycle where lcd_available=1; otherwise it SHALL wait in ISSUE.
REQ-023 The transition ISSUE -> WAIT_ACK SHALL occur after the strobe.
REQ-024 WAIT_ACK -> WAIT_RDY SHALL occur when lcd_available=0.
REQ-025 WAIT_RDY -> ISSUE (next word) SHALL occur when lcd_available=1, or WAIT_RDY -> FINISH if the last word was sent.
REQ-026 FINISH SHALL pulse done for 1 cycle and then go to IDLE.
REQ-027 data and select_cd SHALL remain stable from the strobe cycle until the WAIT_RDY exit.
REQ-028 A WAIT_ACK timeout counter SHALL start at 0 on entry; if it reaches ACK_TO-1 with lcd_available still 1, the module SHALL set err=1, abort to IDLE without a done pulse, and deassert busy.
REQ-029 err SHALL be cleared only by the next accepted start or by reset.
REQ-030 busy SHALL be 1 from the cycle after an accepted start through the FINISH cycle.
REQ-031 A start arriving in the same cycle as FINISH SHALL be ignored.

Reset
REQ-032 While rst_n=0, the module SHALL asynchronously force state=IDLE, data=32'h0, select_cd=1, enable_writing=0, busy=0, done=0, err=0, and clear the word index, timeout counter and captured message.
REQ-033 A reset mid-sequence SHALL drop enable_writing immediately, and no further writes SHALL occur until a new start.

Configuration
REQ-034 The macro LCD_SEQ_REFRESH_EN SHALL select auto-refresh behaviour.
REQ-035 When LCD_SEQ_REFRESH_EN is defined, after FINISH the module SHALL re-capture msg and restart the sequence at the line-0 address command, skipping the clear command, without requiring start; busy SHALL stay 1 and done SHALL still pulse per pass.
REQ-036 When LCD_SEQ_REFRESH_EN is undefined, the module SHALL perform a single pass per start.

Verification
REQ-037 The bench SHALL cover: defaults, msg="HELLO WORLD     " + "DE2 CYCLONE II  ", driver model dropping lcd_available 2 cycles after the strobe for 5 cycles -> 11 strobes in the order 0x01, 0x80, "HELL","O WO","RLD ","    ", 0xC0, "DE2 ","CYCL","ONE ","II  ", then one done pulse.
REQ-038 The bench SHALL cover: lcd_available held 0 when start asserts -> no strobe until it rises; the strobe then occurs in the first cycle it is 1.
REQ-039 The bench SHALL cover: ACK_TO=8, with lcd_available stuck at 1 after the first strobe -> err=1 and busy=0 at 8 cycles after the strobe, with no done pulse.
REQ-040 The bench SHALL cover: a second start and a msg change during the sequence -> both ignored, and the character words match the originally captured msg.
REQ-041 The bench SHALL cover: rst_n low after the 4th strobe -> all outputs at reset values immediately; a new start then restarts from 0x01.
REQ-042 The bench SHALL cover: LCD_SEQ_REFRESH_EN defined, CHARS=4, LINES=1 -> pass 1 sends 0x01, 0x80, word; pass 2 sends 0x80, word; done pulses after each pass.
